// File: rtl/sanduba_pkg.sv
// sanduba_pkg: shared state encoding, default pricing/credit limits and credit type
// for the sanduba_multi vending machine.
package sanduba_pkg;

    localparam int DEF_N_PROD     = 3;
    localparam int DEF_MAX_CREDIT = 32;
    localparam int PRICE_W        = 8;

    // Entry 0 sits in the least-significant byte: req[0]=2, req[1]=3, req[2]=4.
    localparam logic [DEF_N_PROD*PRICE_W-1:0] DEF_PRICES = {8'd4, 8'd3, 8'd2};

    typedef enum logic [1:0] {IDLE, VEND, REFUND, REJECT} state_e;

    typedef logic [$clog2(DEF_MAX_CREDIT+1)-1:0] credit_t;

endpackage

// File: rtl/sanduba_req_dec.sv
// sanduba_req_dec: classifies the IDLE inputs (single vs multiple) and selects the
// requested product's price with a sufficient-funds compare.
module sanduba_req_dec
    import sanduba_pkg::*;
#(
    parameter int                          N_PROD   = DEF_N_PROD,
    parameter int                          CREDIT_W = $clog2(DEF_MAX_CREDIT+1),
    parameter logic [N_PROD*PRICE_W-1:0]   PRICES   = DEF_PRICES,
    parameter int                          IDX_W    = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic                m100,
    input  logic                dev,
    input  logic [N_PROD-1:0]   req,
    input  logic [CREDIT_W-1:0] credit,
    output logic                multi,
    output logic                req_any,
    output logic [IDX_W-1:0]    idx,
    output logic [PRICE_W-1:0]  price,
    output logic                funds_ok
);

    always_comb begin
        idx   = '0;
        price = '0;
        for (int i = 0; i < N_PROD; i++) begin
            if (req[i]) begin
                idx   = i[IDX_W-1:0];
                price = PRICES[i*PRICE_W +: PRICE_W];
            end
        end
    end

    assign multi    = $countones({m100, dev, req}) > 1;
    assign req_any  = |req;
    assign funds_ok = 32'(credit) >= 32'(price);

endmodule

// File: rtl/sanduba_multi.sv
// sanduba_multi: multi-product coin vending FSM with credit register and refund.
// Define SANDUBA_KEEP_CHANGE_EN to keep residual credit after a vend instead of refunding it.
module sanduba_multi
    import sanduba_pkg::*;
#(
    parameter int                          N_PROD     = DEF_N_PROD,
    parameter int                          MAX_CREDIT = DEF_MAX_CREDIT,
    parameter logic [N_PROD*PRICE_W-1:0]   PRICES     = DEF_PRICES,
    localparam int                         CREDIT_W   = $clog2(MAX_CREDIT+1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                m100,
    input  logic                dev,
    input  logic [N_PROD-1:0]   req,
    output logic                d100,
    output logic [N_PROD-1:0]   vend,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    localparam int IDX_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;
`ifdef SANDUBA_KEEP_CHANGE_EN
    localparam bit KEEP_CHANGE = 1'b1;
`else
    localparam bit KEEP_CHANGE = 1'b0;
`endif

    state_e                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [PRICE_W-1:0]    price_q, price_d;

    logic                  multi, req_any, funds_ok;
    logic [IDX_W-1:0]      sel_idx;
    logic [PRICE_W-1:0]    sel_price;
    logic                  below_max;

    sanduba_req_dec #(
        .N_PROD   (N_PROD),
        .CREDIT_W (CREDIT_W),
        .PRICES   (PRICES),
        .IDX_W    (IDX_W)
    ) u_dec (
        .m100     (m100),
        .dev      (dev),
        .req      (req),
        .credit   (credit_q),
        .multi    (multi),
        .req_any  (req_any),
        .idx      (sel_idx),
        .price    (sel_price),
        .funds_ok (funds_ok)
    );

    assign below_max = credit_q < CREDIT_W'(MAX_CREDIT);

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        idx_d    = idx_q;
        price_d  = price_q;
        case (state_q)
            IDLE: begin
                if (multi) begin
                    // A coin arriving with other inputs is still banked, but never rejected.
                    credit_d = (m100 && below_max) ? credit_q + CREDIT_W'(1) : credit_q;
                    state_d  = REFUND;
                end else if (m100) begin
                    credit_d = below_max ? credit_q + CREDIT_W'(1) : credit_q;
                    state_d  = below_max ? IDLE : REJECT;
                end else if (dev) begin
                    state_d = REFUND;
                end else if (req_any) begin
                    state_d = funds_ok ? VEND : REFUND;
                    idx_d   = funds_ok ? sel_idx : idx_q;
                    price_d = funds_ok ? sel_price : price_q;
                end
            end
            VEND: begin
                credit_d = CREDIT_W'(32'(credit_q) - 32'(price_q));
                state_d  = KEEP_CHANGE ? IDLE : REFUND;
            end
            REFUND: begin
                credit_d = (credit_q != '0) ? credit_q - CREDIT_W'(1) : credit_q;
                state_d  = (credit_q != '0) ? REFUND : IDLE;
            end
            REJECT: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            credit_q <= '0;
            idx_q    <= '0;
            price_q  <= '0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            idx_q    <= idx_d;
            price_q  <= price_d;
        end
    end

    assign busy   = state_q != IDLE;
    assign d100   = (state_q == REJECT) || (state_q == REFUND && credit_q != '0);
    assign vend   = (state_q == VEND) ? (N_PROD'(1) << idx_q) : '0;
    assign credit = credit_q;

endmodule

// File: tb/tb_sanduba_multi.sv
// tb_sanduba_multi: directed and random checks of sanduba_multi against a transaction-level model.
module tb_sanduba_multi;

    localparam int NP   = 3;
    localparam int MAXC = 32;
    localparam int CW   = $clog2(MAXC+1);
    localparam int PR [NP] = '{2, 3, 4};
`ifdef SANDUBA_KEEP_CHANGE_EN
    localparam bit KEEP = 1'b1;
`else
    localparam bit KEEP = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          m100  = 1'b0;
    logic          dev   = 1'b0;
    logic [NP-1:0] req   = '0;
    logic          d100;
    logic [NP-1:0] vend;
    logic          busy;
    logic [CW-1:0] credit;

    always #5 clock = ~clock;

    sanduba_multi dut (
        .clock  (clock),
        .reset  (reset),
        .m100   (m100),
        .dev    (dev),
        .req    (req),
        .d100   (d100),
        .vend   (vend),
        .busy   (busy),
        .credit (credit)
    );

    typedef struct {
        logic [NP-1:0] vend;
        logic          d100;
        logic          busy;
        int            credit;
    } exp_t;

    exp_t q[$];
    int   mc     = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic push(input logic [NP-1:0] v, input logic d, input int c);
        exp_t e;
        e.vend = v; e.d100 = d; e.busy = 1'b1; e.credit = c;
        q.push_back(e);
    endtask

    // A refund shows one coin per cycle counting the credit down, then one empty busy cycle.
    task automatic refund();
        for (int k = mc; k > 0; k--) push('0, 1'b1, k);
        push('0, 1'b0, 0);
        mc = 0;
    endtask

    task automatic accept(input logic m, input logic d, input logic [NP-1:0] r);
        int n;
        int i;
        n = int'(m) + int'(d) + $countones(r);
        i = 0;
        if (n > 1) begin
            if (m && mc < MAXC) mc++;
            refund();
        end else if (m) begin
            if (mc < MAXC) mc++;
            else push('0, 1'b1, mc);
        end else if (d) begin
            refund();
        end else if (n == 1) begin
            for (int j = 0; j < NP; j++) if (r[j]) i = j;
            if (mc >= PR[i]) begin
                push(NP'(1 << i), 1'b0, mc);
                mc -= PR[i];
                if (!KEEP) refund();
            end else begin
                refund();
            end
        end
    endtask

    task automatic check(input string tag, output bit idle);
        exp_t e;
        idle = (q.size() == 0);
        if (idle) begin
            e.vend = '0; e.d100 = 1'b0; e.busy = 1'b0; e.credit = mc;
        end else begin
            e = q.pop_front();
        end
        checks += 4;
        assert (vend === e.vend) else begin
            errors++;
            $error("FAIL %s vend got %b exp %b", tag, vend, e.vend);
        end
        assert (d100 === e.d100) else begin
            errors++;
            $error("FAIL %s d100 got %b exp %b", tag, d100, e.d100);
        end
        assert (busy === e.busy) else begin
            errors++;
            $error("FAIL %s busy got %b exp %b", tag, busy, e.busy);
        end
        assert (credit === CW'(e.credit)) else begin
            errors++;
            $error("FAIL %s credit got %0d exp %0d", tag, credit, e.credit);
        end
    endtask

    // Check the cycle now visible, then present inputs for the coming edge.
    task automatic step(input string tag, input logic m, input logic d,
                        input logic [NP-1:0] r, input logic rst);
        bit idle;
        @(negedge clock);
        check(tag, idle);
        m100 = m; dev = d; req = r; reset = rst;
        if (rst) begin
            q.delete();
            mc = 0;
        end else if (idle) begin
            accept(m, d, r);
        end
    endtask

    // Inputs while busy are randomized because the machine must ignore them.
    task automatic drain(input string tag);
        int n;
        n = 0;
        while (q.size() > 0 && n < 200) begin
            step(tag, 1'($urandom), 1'($urandom), NP'($urandom), 1'b0);
            n++;
        end
    endtask

    task automatic coins(input string tag, input int n);
        for (int k = 0; k < n; k++) step(tag, 1'b1, 1'b0, '0, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        step("reset", 1'b0, 1'b0, '0, 1'b0);

        coins("vend1", 5);
        step("vend1", 1'b0, 1'b0, 3'b010, 1'b0);
        drain("vend1");

        coins("short", 1);
        step("short", 1'b0, 1'b0, 3'b100, 1'b0);
        drain("short");

        coins("full", 32);
        step("full", 1'b1, 1'b0, '0, 1'b0);
        drain("reject");
        step("full_dev", 1'b0, 1'b1, '0, 1'b0);
        drain("full_dev");

        coins("multi", 3);
        step("multi", 1'b0, 1'b0, 3'b011, 1'b0);
        drain("multi");

        coins("multi_max", 32);
        step("multi_max", 1'b1, 1'b1, '0, 1'b0);
        drain("multi_max");

        coins("rst_vend", 4);
        step("rst_vend", 1'b0, 1'b0, 3'b100, 1'b0);
        step("rst_vend", 1'b0, 1'b0, '0, 1'b1);
        for (int k = 0; k < 4; k++) step("post_rst", 1'b0, 1'b0, '0, 1'b0);

        coins("rst_ref", 6);
        step("rst_ref", 1'b0, 1'b1, '0, 1'b0);
        step("rst_ref", 1'b0, 1'b0, '0, 1'b0);
        step("rst_ref", 1'b0, 1'b0, '0, 1'b1);
        for (int k = 0; k < 4; k++) step("post_rst2", 1'b0, 1'b0, '0, 1'b0);

        coins("keep", 5);
        step("keep", 1'b0, 1'b0, 3'b001, 1'b0);
        drain("keep");
        step("keep_dev", 1'b0, 1'b1, '0, 1'b0);
        drain("keep_dev");

        for (int t = 0; t < 600; t++) begin
            int sel;
            logic [NP-1:0] r;
            sel = $urandom_range(0, 15);
            r = '0;
            if (sel >= 10 && sel <= 12) r[$urandom_range(0, NP-1)] = 1'b1;
            if (sel == 13) r = NP'($urandom);
            step("random", sel <= 8 || sel == 13, sel == 9, r, $urandom_range(0, 79) == 0);
        end
        drain("final");
        step("final", 1'b0, 1'b0, '0, 1'b0);
        step("final", 1'b0, 1'b0, '0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
